pipeline_arbiter: RTL

PIPELINE_ARBITER -- requirements
Module: pipeline_arbiter

---
 rtl/arb_pkg.sv | 15 +
 rtl/rr_arbiter.sv | 27 ++
 rtl/pipeline_arbiter.sv | 127 ++++++++++++
 3 files changed

// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared state encoding and defaults for the pipeline arbiter
package arb_pkg;

  typedef enum logic [1:0] {
    A_IDLE,
    A_ISSUE,
    A_WAIT_OUT,
    A_WAIT_ATTR
  } arb_state_t;

  localparam int N_SRC_DEFAULT   = 4;
  localparam int SRC_IDX_W       = $clog2(N_SRC_DEFAULT);
  localparam int TIMEOUT_DEFAULT = 1024;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin priority encoder
module rr_arbiter #(
  parameter int  N     = 4,
  localparam int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last_grant,
  output logic             any,
  output logic [IDX_W-1:0] grant_idx
);

  // Scan from the source after the last grant, wrapping, first hit wins.
  always_comb begin
    logic [IDX_W-1:0] idx;
    any       = 1'b0;
    grant_idx = '0;
    idx       = '0;
    for (int k = 1; k <= N; k++) begin
      idx = IDX_W'((int'(last_grant) + k) % N);
      if (!any && req[idx]) begin
        any       = 1'b1;
        grant_idx = idx;
      end
    end
  end

endmodule

// File: rtl/pipeline_arbiter.sv
// rtl/pipeline_arbiter.sv - single-transaction arbiter feeding one instrumented pipeline
module pipeline_arbiter
  import arb_pkg::*;
#(
  parameter int  N_SRC   = N_SRC_DEFAULT,
  parameter int  TIMEOUT = TIMEOUT_DEFAULT,
  localparam int IDX_W   = $clog2(N_SRC)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_SRC-1:0]       src_valid,
  output logic [N_SRC-1:0]       src_ready,
  input  logic [N_SRC-1:0][63:0] src_data,
  input  logic [N_SRC-1:0]       cfg_src_en,
  output logic                   pipe_up_valid,
  input  logic                   pipe_up_ready,
  output logic [63:0]            pipe_up_data,
  input  logic                   pipe_dn_valid,
  output logic                   pipe_dn_ready,
  input  logic [63:0]            pipe_dn_data,
  input  logic                   pipe_attr_valid,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [63:0]            out_data,
  output logic [IDX_W-1:0]       out_src,
  output logic                   attr_src_valid,
  output logic [IDX_W-1:0]       attr_src,
  output logic                   busy,
  output logic                   err_timeout,
  output logic [31:0]            txn_count
);

  arb_state_t       state_q, state_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [IDX_W-1:0] last_grant_q, last_grant_d;
  logic [31:0]      wdog_q, wdog_d;
  logic [31:0]      txn_count_q, txn_count_d;
  logic             err_q, err_d;
  logic [N_SRC-1:0] req;
  logic             rr_any;
  logic [IDX_W-1:0] rr_idx;

  assign req = src_valid & cfg_src_en;

  rr_arbiter #(.N(N_SRC)) u_rr (
    .req        (req),
    .last_grant (last_grant_q),
    .any        (rr_any),
    .grant_idx  (rr_idx)
  );

  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    last_grant_d   = last_grant_q;
    wdog_d         = wdog_q;
    txn_count_d    = txn_count_q;
    src_ready      = '0;
    pipe_up_valid  = 1'b0;
    pipe_up_data   = '0;
    pipe_dn_ready  = 1'b0;
    out_valid      = 1'b0;
    out_data       = '0;
    attr_src_valid = 1'b0;
    case (state_q)
      A_IDLE: begin
        if (rr_any) begin
          owner_d = rr_idx;
          wdog_d  = '0;
          state_d = A_ISSUE;
        end
      end
      // Owner is latched, so a late cfg_src_en drop cannot cancel the issue.
      A_ISSUE: begin
        pipe_up_valid      = 1'b1;
        pipe_up_data       = src_data[owner_q];
        src_ready[owner_q] = pipe_up_ready;
        if (pipe_up_ready) begin
          last_grant_d = owner_q;
          state_d      = A_WAIT_OUT;
        end
      end
      A_WAIT_OUT: begin
        wdog_d        = wdog_q + 32'd1;
        out_valid     = pipe_dn_valid;
        out_data      = pipe_dn_data;
        pipe_dn_ready = out_ready;
        if (pipe_dn_valid && out_ready) state_d = A_WAIT_ATTR;
      end
      A_WAIT_ATTR: begin
        wdog_d = wdog_q + 32'd1;
        if (pipe_attr_valid) begin
          attr_src_valid = 1'b1;
          txn_count_d    = txn_count_q + 32'd1;
          state_d        = A_IDLE;
        end
      end
      default: state_d = A_IDLE;
    endcase
    err_d = err_q | (wdog_d == 32'(TIMEOUT));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= A_IDLE;
      owner_q      <= '0;
      last_grant_q <= IDX_W'(N_SRC - 1);
      wdog_q       <= '0;
      txn_count_q  <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      wdog_q       <= wdog_d;
      txn_count_q  <= txn_count_d;
      err_q        <= err_d;
    end
  end

  assign out_src     = owner_q;
  assign attr_src    = owner_q;
  assign busy        = (state_q != A_IDLE);
  assign err_timeout = err_q;
  assign txn_count   = txn_count_q;

endmodule
